// File: rtl/stat_counter_bank_if.sv
// rtl/stat_counter_bank_if.sv - display FIFO stream bundle for stat_counter_bank
interface stat_counter_bank_if;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic        disp_ready;

  modport master (output disp_valid, output disp_data, input disp_ready);
  modport slave  (input disp_valid, input disp_data, output disp_ready);
endinterface

// File: rtl/stat_counter_bank.sv
// rtl/stat_counter_bank.sv - event counter bank with shadow snapshot and syscall display FIFO
module stat_counter_bank #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int SAT_MODE   = 0,
  parameter int SHOW_CODE  = 34,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ev,
  input  logic                      clr,
  input  logic                      snap,
  input  logic [$clog2(NUM_CH)-1:0] rd_idx,
  output logic [CNT_W-1:0]          rd_data,
  output logic [NUM_CH-1:0]         ovf,
  input  logic [31:0]               sys_a,
  input  logic [31:0]               sys_b,
  input  logic                      syscall_t,
  stat_counter_bank_if.master       disp,
  output logic [31:0]               disp_last,
  output logic [7:0]                disp_drops
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [31:0]      last_q, last_d;
  logic [7:0]       drops_q, drops_d;
  logic             push, pop, full, enq;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      ovf_d[i]    = ovf_q[i];
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (run && ev[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = (SAT_MODE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Out-of-range selects only exist when NUM_CH is not a power of two.
    rd_data_d = (32'(rd_idx) < NUM_CH) ? shadow_q[rd_idx] : '0;
  end

  always_comb begin
    push     = syscall_t && (sys_a == 32'(SHOW_CODE));
    full     = (occ_q == OCC_W'(FIFO_DEPTH));
    pop      = (occ_q != '0) && disp.disp_ready;
    enq      = push && (!full || pop);
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (enq && !pop)
      occ_d = occ_q + 1'b1;
    else if (pop && !enq)
      occ_d = occ_q - 1'b1;
    last_d  = push ? sys_b : last_q;
    drops_d = drops_q;
    if (push && full && !pop && drops_q != 8'hFF)
      drops_d = drops_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q     <= '0;
      rd_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      last_q    <= '0;
      drops_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      last_q    <= last_d;
      drops_q   <= drops_d;
    end
  end

  // Storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (!rst && enq)
      mem_q[wr_ptr_q] <= sys_b;
  end

  assign rd_data         = rd_data_q;
  assign ovf             = ovf_q;
  assign disp.disp_valid = (occ_q != '0);
  assign disp.disp_data  = mem_q[rd_ptr_q];
  assign disp_last       = last_q;
  assign disp_drops      = drops_q;
endmodule
